// File: rtl/icache_mem_responder.sv
// ============================================================================
// Module   : icache_mem_responder
// Purpose  : Memory-side block-read responder with tagged, fixed-latency returns.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_mem_responder #(
    parameter int LATENCY         = 4,
    parameter int NUM_MEM_TAGS    = 15,
    parameter int MAX_OUTSTANDING = NUM_MEM_TAGS,
    parameter int MEM_BLOCKS      = 1024,
    localparam int TAG_W          = $clog2(NUM_MEM_TAGS + 1),
    localparam int IDX_W          = $clog2(MEM_BLOCKS),
    localparam int CNT_W          = $clog2(NUM_MEM_TAGS) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             mem_req_valid_i,
    input  logic [31:0]      mem_req_addr_i,
    output logic             mem_req_accepted_o,
    output logic [TAG_W-1:0] current_req_tag_o,
    output logic [63:0]      mem_data_o,
    output logic [TAG_W-1:0] mem_data_tag_o,
    input  logic             preload_en_i,
    input  logic [IDX_W-1:0] preload_idx_i,
    input  logic [63:0]      preload_data_i,
    output logic [CNT_W-1:0] outstanding_dbg_o
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_MEM_TAGS);
    localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);

    logic [63:0]      store_q [MEM_BLOCKS];
    logic [TAG_W-1:0] tag_pipe_q  [LATENCY];
    logic [63:0]      data_pipe_q [LATENCY];

    logic [TAG_W-1:0] next_tag_q, next_tag_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [IDX_W-1:0] rd_idx;
    logic [63:0]      rd_data;
    logic             returning;
    logic             unused_addr_bits;

    // Block offset and upper zero bits carry no information for the store.
    assign rd_idx           = mem_req_addr_i[3 +: IDX_W];
    assign unused_addr_bits = ^{mem_req_addr_i[31:3+IDX_W], mem_req_addr_i[2:0]};
    assign rd_data          = store_q[rd_idx];

    // Gating with reset keeps the handshake quiet while reset is held.
    assign mem_req_accepted_o = reset_i & mem_req_valid_i & (outstanding_q < MAX_CNT);
    assign current_req_tag_o  = mem_req_accepted_o ? next_tag_q : '0;

    assign mem_data_tag_o    = tag_pipe_q[LATENCY-1];
    assign mem_data_o        = data_pipe_q[LATENCY-1];
    assign returning         = (mem_data_tag_o != '0);
    assign outstanding_dbg_o = outstanding_q;

    always_comb begin
        next_tag_d = next_tag_q;
        if (mem_req_accepted_o) begin
            next_tag_d = (next_tag_q == LAST_TAG) ? FIRST_TAG : next_tag_q + FIRST_TAG;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({mem_req_accepted_o, returning})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            next_tag_q    <= FIRST_TAG;
            outstanding_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe_q[i]  <= '0;
                data_pipe_q[i] <= '0;
            end
        end else begin
            next_tag_q     <= next_tag_d;
            outstanding_q  <= outstanding_d;
            tag_pipe_q[0]  <= current_req_tag_o;
            data_pipe_q[0] <= mem_req_accepted_o ? rd_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe_q[i]  <= tag_pipe_q[i-1];
                data_pipe_q[i] <= data_pipe_q[i-1];
            end
        end
    end

    // Store contents survive reset; the read above sees pre-edge data.
    always_ff @(posedge clock_i) begin
        if (preload_en_i) begin
            store_q[preload_idx_i] <= preload_data_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_mem_responder.sv
// ============================================================================
// Module   : tb_icache_mem_responder
// Purpose  : Directed self-checking bench for icache_mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_icache_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        pre_en;
    logic [9:0]  pre_idx;
    logic [63:0] pre_data;
    logic        acc;
    logic [3:0]  req_tag;
    logic [63:0] data;
    logic [3:0]  data_tag;
    logic [4:0]  outst;

    logic        t_valid;
    logic        t_acc;
    logic [3:0]  t_req_tag;
    logic [63:0] t_data;
    logic [3:0]  t_data_tag;
    logic [4:0]  t_outst;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] DA = 64'hAAAA_0000_0000_0007;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_0007;

    always #5 clk = ~clk;

    icache_mem_responder u_dut (
        .clock_i            (clk),
        .reset_i            (rst_n),
        .mem_req_valid_i    (req_valid),
        .mem_req_addr_i     (req_addr),
        .mem_req_accepted_o (acc),
        .current_req_tag_o  (req_tag),
        .mem_data_o         (data),
        .mem_data_tag_o     (data_tag),
        .preload_en_i       (pre_en),
        .preload_idx_i      (pre_idx),
        .preload_data_i     (pre_data),
        .outstanding_dbg_o  (outst)
    );

    icache_mem_responder #(.MAX_OUTSTANDING(2)) u_thr (
        .clock_i            (clk),
        .reset_i            (rst_n),
        .mem_req_valid_i    (t_valid),
        .mem_req_addr_i     (32'h0000_0000),
        .mem_req_accepted_o (t_acc),
        .current_req_tag_o  (t_req_tag),
        .mem_data_o         (t_data),
        .mem_data_tag_o     (t_data_tag),
        .preload_en_i       (1'b0),
        .preload_idx_i      (10'd0),
        .preload_data_i     (64'd0),
        .outstanding_dbg_o  (t_outst)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set here apply to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        pre_en    = 1'b0;
        t_valid   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [63:0] d);
        pre_en   = 1'b1;
        pre_idx  = idx;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    logic [63:0] blk [4];
    bit   exp_acc  [8] = '{1, 1, 0, 0, 0, 1, 1, 0};
    int   exp_tag  [8] = '{1, 2, 0, 0, 0, 3, 4, 0};
    int   exp_rtag [8] = '{0, 0, 0, 0, 1, 2, 0, 0};

    initial begin
        rst_n    = 1'b0;
        pre_idx  = '0;
        pre_data = '0;
        idle();
        req_valid = 1'b1;
        tick();
        #1;
        check("reset_acc", acc, 0);
        check("reset_tag", req_tag, 0);
        check("reset_dtag", data_tag, 0);
        check("reset_data", data, 0);
        check("reset_outst", outst, 0);
        do_reset();

        // Single request
        preload(10'd5, 64'hDEAD_BEEF_0123_4567);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0028;
        #1;
        check("single_acc", acc, 1);
        check("single_tag", req_tag, 1);
        tick();
        idle();
        for (int c = 1; c < 4; c++) begin
            check("single_wait_dtag", data_tag, 0);
            tick();
        end
        check("single_ret_tag", data_tag, 1);
        check("single_ret_data", data, 64'hDEAD_BEEF_0123_4567);
        tick();
        check("single_after_tag", data_tag, 0);
        check("single_after_data", data, 0);
        check("single_outst", outst, 0);

        // Back-to-back
        do_reset();
        for (int b = 1; b < 4; b++) begin
            blk[b] = {32'hB10C_0000, 32'(b * 32'h1111)};
            preload(10'(b), blk[b]);
        end
        for (int b = 1; b < 4; b++) begin
            req_valid = 1'b1;
            req_addr  = 32'(b << 3);
            #1;
            check("b2b_tag", req_tag, 64'(b));
            tick();
        end
        idle();
        check("b2b_peak", outst, 3);
        tick();
        for (int b = 1; b < 4; b++) begin
            check("b2b_ret_tag", data_tag, 64'(b));
            check("b2b_ret_data", data, blk[b]);
            tick();
        end
        check("b2b_outst_zero", outst, 0);
        check("b2b_idle_tag", data_tag, 0);

        // Throttle on the MAX_OUTSTANDING=2 instance
        do_reset();
        t_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("thr_acc", t_acc, 64'(exp_acc[c]));
            check("thr_tag", t_req_tag, 64'(exp_tag[c]));
            check("thr_ret", t_data_tag, 64'(exp_rtag[c]));
            tick();
        end
        check("thr_outst_cap", t_outst, 2);
        idle();

        // Tag wrap
        do_reset();
        for (int i = 0; i < 15; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0;
            #1;
            check("wrap_tag", req_tag, 64'(i + 1));
            tick();
        end
        #1;
        check("wrap_acc", acc, 1);
        check("wrap_tag_back_to_1", req_tag, 1);
        tick();
        idle();
        for (int i = 0; i < 6; i++) tick();
        check("wrap_drained", outst, 0);

        // Mid-flight reset
        do_reset();
        req_valid = 1'b1;
        tick();
        tick();
        idle();
        tick();
        check("mid_outst_before", outst, 2);
        rst_n = 1'b0;
        #1;
        check("mid_dtag_on_assert", data_tag, 0);
        check("mid_outst_on_assert", outst, 0);
        req_valid = 1'b1;
        #1;
        check("mid_acc_in_reset", acc, 0);
        req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("mid_no_stale", data_tag, 0);
            tick();
        end
        req_valid = 1'b1;
        #1;
        check("mid_first_tag", req_tag, 1);
        tick();
        idle();

        // Same-cycle preload/read hazard
        do_reset();
        preload(10'd7, DA);
        pre_en    = 1'b1;
        pre_idx   = 10'd7;
        pre_data  = DB;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0038;
        tick();
        pre_en = 1'b0;
        tick();
        idle();
        tick();
        tick();
        check("haz_old_tag", data_tag, 1);
        check("haz_old_data", data, DA);
        tick();
        check("haz_new_tag", data_tag, 2);
        check("haz_new_data", data, DB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/icache_mem_responder.md
Name: icache_mem_responder

Overview:
- Memory-side responder for the icache request/refill protocol: accepts one block-read request per cycle and issues a nonzero MEM_TAG on acceptance.
- Returns the 64-bit block with that tag exactly LATENCY cycles later, in order.
- Backs the requests with a behavioural block store, which the bench preloads through a write port.
- Sits on the arbiter/mem side of the icache subsystem; it is the producer of mem_req_accepted, current_req_tag, mem_data and mem_data_tag.

Parameters:
- LATENCY, 4, cycles from the accept cycle to the data-return cycle (>=1).
- MAX_OUTSTANDING, `NUM_MEM_TAGS, maximum accepted-but-unreturned requests (1..`NUM_MEM_TAGS).
- MEM_BLOCKS, 1024, store depth in 8-byte blocks (power of 2).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- mem_req_addr  input  I_ADDR_PACKET  request: valid, plus address {zeros, tag, block_offset}.
- mem_req_accepted  output  1  request accepted this cycle (combinational).
- current_req_tag  output  MEM_TAG  tag issued to the accepted request (combinational); 0 when not accepting.
- mem_data  output  MEM_BLOCK  returned block (registered); 0 when mem_data_tag==0.
- mem_data_tag  output  MEM_TAG  tag of the returned block (registered); 0 = no data.
- preload_en  input  1  store write enable.
- preload_idx  input  $clog2(MEM_BLOCKS)  block index to write.
- preload_data  input  MEM_BLOCK  write data.
- outstanding_dbg  output  $clog2(`NUM_MEM_TAGS)+1  current outstanding count.

Behaviour:
- Reset (reset==0, asynchronous):
  - mem_data, mem_data_tag, the return pipeline and outstanding all clear to 0; next_tag is set to 1.
  - In-flight requests are dropped and never returned.
  - The store is not reset.
  - mem_req_accepted stays 0 while reset is asserted.
- Accept rule: mem_req_accepted = mem_req_addr.valid & (outstanding < MAX_OUTSTANDING).
  - The count is the registered value; a return in the same cycle gives no same-cycle credit.
- Tag issue:
  - current_req_tag = next_tag when accepting, else 0.
  - next_tag advances on each accept: 1,2,...,`NUM_MEM_TAGS, then wraps to 1. Tag 0 is never issued.
- Block index = mem_req_addr.addr.tag[$clog2(MEM_BLOCKS)-1:0]. block_offset and zeros are ignored.
- Store read occurs in the accept cycle. A preload to the same index in the same cycle does not affect the read; the read returns the old data and the write lands at the clock edge.
- Return pipeline:
  - LATENCY-stage shift register of {tag, data}.
  - A request accepted in cycle T appears on mem_data_tag/mem_data during cycle T+LATENCY, for exactly one cycle.
  - In-order; at most one return per cycle, so no return conflicts exist.
- Outstanding counter:
  - +1 at the edge ending an accept cycle; -1 at the edge ending a return cycle.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Empty (no outstanding requests): mem_data_tag=0 and mem_data=0 every cycle.
- Full (outstanding==MAX_OUTSTANDING): requests are refused (accepted=0, tag=0). The requester holds or retries; this block has no queue beyond the pipeline.
- Preload is permitted at any time, including while requests are in flight; the new contents are visible to accepts in later cycles only.

Test Plan:
- Single request:
  - Preload idx 5 = 64'hDEAD_BEEF_0123_4567; in cycle 10 drive valid addr 32'h0000_0028.
  - Expect accepted=1, current_req_tag=1 in cycle 10.
  - Expect mem_data_tag=1 and mem_data=64'hDEAD_BEEF_0123_4567 in cycle 14 (LATENCY 4), then tag 0 in cycle 15.
- Back-to-back:
  - Valid requests to blocks 1, 2, 3 in cycles 20–22.
  - Expect tags 1, 2, 3 issued, and returned in cycles 24, 25, 26 with the matching data.
  - Expect outstanding_dbg to peak at 3 and reach 0 in cycle 27.
- Throttle, with MAX_OUTSTANDING=2, LATENCY=4 and valid held high from cycle 0:
  - Expect accepts in cycles 0, 1; refusals (accepted=0, tag=0) in cycles 2–4.
  - Expect returns in cycles 4, 5; the next accepts in cycles 5 and 6.
- Tag wrap: issue `NUM_MEM_TAGS accepts, with each return consumed; expect the next accept to get tag 1 and never tag 0.
- Mid-flight reset:
  - Accept 2 requests, then pull reset low for 1 cycle before their return cycle.
  - Expect mem_data_tag=0 immediately on assertion and no stale return after release.
  - Expect the next accept to get tag 1.
- Same-cycle hazard: preload idx 7 = A; in one cycle, preload idx 7 = B and request block 7. Expect the return to carry A; a later request to block 7 returns B.
